// File: rtl/uart_pkg.sv
// Shared types and constants for the line-oriented UART transmitter.
// Holds the line FSM encoding, ASCII control bytes and baud-divider helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_CR    = 3'd5,
    ST_LF    = 3'd6
  } line_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // Rounded clocks-per-bit, clamped so every bit spans at least two clocks.
  function automatic int unsigned calc_baud_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    int unsigned div_v;
    div_v = (clk_hz + (baud / 32'd2)) / baud;
    if (div_v < 32'd2) begin
      div_v = 32'd2;
    end else begin
      div_v = div_v;
    end
    return div_v;
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned baud_div);
    int unsigned w_v;
    w_v = $clog2(baud_div);
    if (w_v < 32'd1) begin
      w_v = 32'd1;
    end else begin
      w_v = w_v;
    end
    return w_v;
  endfunction

endpackage

// File: rtl/uart_tx_bit.sv
// Single 8N1 frame serialiser: start bit, eight data bits LSB first, stop bit.
// A load strobe (which may coincide with frame_done) starts a new frame at once.
module uart_tx_bit
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       frame_done,
  output logic       bit_end,
  output logic       in_stop,
  output logic       tx
);

  localparam int unsigned     CNT_W     = calc_cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 32'd1);
  localparam logic [CNT_W-1:0] BAUD_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] baud_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             active_r;
  logic             tx_r;
  logic             bit_end_s;

  // bit_cnt_r: 0 = start bit, 1..8 = data bits, 9 = stop bit
  assign bit_end_s  = active_r && (baud_cnt_r == BAUD_LAST);
  assign bit_end    = bit_end_s;
  assign frame_done = bit_end_s && (bit_cnt_r == 4'd9);
  assign in_stop    = active_r && (bit_cnt_r == 4'd9);
  assign tx         = tx_r;

  // Baud counter, bit counter, shift register and registered line driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      active_r   <= 1'b0;
      tx_r       <= 1'b1;
    end else if (load) begin
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 4'd0;
      shift_r    <= data;
      active_r   <= 1'b1;
      tx_r       <= 1'b0;
    end else if (bit_end_s) begin
      baud_cnt_r <= BAUD_ZERO;
      if (bit_cnt_r < 4'd8) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
        tx_r      <= shift_r[0];
        shift_r   <= {1'b0, shift_r[7:1]};
      end else if (bit_cnt_r == 4'd8) begin
        bit_cnt_r <= 4'd9;
        tx_r      <= 1'b1;
      end else begin
        bit_cnt_r <= 4'd0;
        active_r  <= 1'b0;
        tx_r      <= 1'b1;
      end
    end else if (active_r) begin
      baud_cnt_r <= baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      baud_cnt_r <= BAUD_ZERO;
    end
  end

endmodule

// File: rtl/uart_line_tx.sv
// Sends one 32-character text line as UART 8N1 per start pulse, optionally
// followed by CR/LF; scans the character source through the index port.
module uart_line_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned LINE_LEN  = 32,
  parameter int unsigned SEND_CRLF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
  localparam logic [4:0]  LAST_IDX = 5'(LINE_LEN - 32'd1);

  line_state_e state_r, state_s;
  logic [4:0]  index_r, index_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        fetch_cnt_r, fetch_cnt_s;
  logic        load_s;
  logic [7:0]  load_byte_s;
  logic        frame_done_s;
  logic        bit_end_s;
  logic        in_stop_s;

  uart_tx_bit #(
    .BAUD_DIV(BAUD_DIV)
  ) u_bit (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .data      (load_byte_s),
    .frame_done(frame_done_s),
    .bit_end   (bit_end_s),
    .in_stop   (in_stop_s),
    .tx        (tx)
  );

  assign index = index_r;
  assign busy  = busy_r;
  assign done  = done_r;

  // Line sequencer state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      index_r     <= 5'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fetch_cnt_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      index_r     <= index_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      fetch_cnt_r <= fetch_cnt_s;
    end
  end

  // Next-state decode; frame loads happen on the same edge that ends the
  // previous stop bit so CR/LF follow with no gap.
  always_comb begin
    state_s     = state_r;
    index_s     = index_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    fetch_cnt_s = fetch_cnt_r;
    load_s      = 1'b0;
    load_byte_s = char_in;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          state_s     = ST_FETCH;
          index_s     = 5'd0;
          busy_s      = 1'b1;
          fetch_cnt_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // the source is registered, so char_in is valid on the second clock
        if (fetch_cnt_r) begin
          load_s      = 1'b1;
          load_byte_s = char_in;
          fetch_cnt_s = 1'b0;
          state_s     = ST_START;
        end else begin
          fetch_cnt_s = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (in_stop_s) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (frame_done_s) begin
          if (index_r < LAST_IDX) begin
            index_s     = index_r + 5'd1;
            fetch_cnt_s = 1'b0;
            state_s     = ST_FETCH;
          end else if (SEND_CRLF != 32'd0) begin
            load_s      = 1'b1;
            load_byte_s = ASCII_CR;
            state_s     = ST_CR;
          end else begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            index_s = 5'd0;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_CR: begin
        if (frame_done_s) begin
          load_s      = 1'b1;
          load_byte_s = ASCII_LF;
          state_s     = ST_LF;
        end else begin
          state_s = ST_CR;
        end
      end
      ST_LF: begin
        if (frame_done_s) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          index_s = 5'd0;
        end else begin
          state_s = ST_LF;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        index_s = 5'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_line_tx.sv
// Scoreboard bench: stimulus queues expected bytes, independent monitors
// decode tx, track index steps and busy/done timing, and compare.
module tb_uart_line_tx;
  import uart_pkg::*;

  localparam int B       = 10;
  localparam int LEN_CR  = 3464;
  localparam int LEN_NO  = 3264;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] char_a, char_b;
  logic [4:0] index_a, index_b;
  logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  uart_line_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .LINE_LEN(32), .SEND_CRLF(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .char_in(char_a),
    .index(index_a), .tx(tx_a), .busy(busy_a), .done(done_a));

  uart_line_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .LINE_LEN(32), .SEND_CRLF(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .char_in(char_b),
    .index(index_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  // registered character sources, one clock behind index
  always @(posedge clk) begin
    char_a <= (index_a == 5'd3) ? 8'h55 : ASCII_SP;
    char_b <= 8'h40 + {3'b000, index_b};
  end

  logic       tx_v [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic [4:0] idx_v [2];
  assign tx_v[0]   = tx_a;    assign tx_v[1]   = tx_b;
  assign busy_v[0] = busy_a;  assign busy_v[1] = busy_b;
  assign done_v[0] = done_a;  assign done_v[1] = done_b;
  assign idx_v[0]  = index_a; assign idx_v[1]  = index_b;

  int n_cmp = 0;
  int n_bad = 0;
  int gen [2];
  int done_cnt [2];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic decode_loop(input int d);
    logic [7:0] b;
    logic [7:0] e;
    logic       st, sp;
    int         g;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_v[d] === 1'b0) begin
        g = gen[d];
        repeat (4) @(negedge clk);
        st = tx_v[d];
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = tx_v[d];
        end
        repeat (B) @(negedge clk);
        sp = tx_v[d];
        if (g == gen[d]) begin
          if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
            check(d == 0 ? "unexpected frame a" : "unexpected frame b", {22'd0, st, sp, b}, 32'hFFFF_FFFF);
          end else begin
            e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
            check(d == 0 ? "frame a" : "frame b", {22'd0, st, sp, b}, {22'd0, 1'b0, 1'b1, e});
            if (d == 1) begin
              check("no cr/lf when disabled", {31'd0, (b == ASCII_CR) || (b == ASCII_LF)}, 32'd0);
            end
          end
        end
      end
    end
  endtask

  task automatic idx_loop(input int d);
    logic [4:0] prev;
    logic       rst_seen;
    prev = 5'd0;
    rst_seen = 1'b1;
    forever begin
      @(negedge clk);
      if (idx_v[d] !== prev) begin
        if (rst_seen !== 1'b1) begin
          check(d == 0 ? "index step a" : "index step b", {27'd0, idx_v[d]},
                {27'd0, (prev == 5'd31) ? 5'd0 : prev + 5'd1});
        end
        prev = idx_v[d];
      end
      rst_seen = rst;
    end
  endtask

  task automatic busy_loop(input int d, input int exp_len);
    int   cnt;
    logic prev_done;
    cnt = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        cnt = 0;
      end else if (done_v[d] === 1'b1) begin
        check(d == 0 ? "busy length a" : "busy length b", cnt, exp_len);
        check("done one clock", {31'd0, prev_done}, 32'd0);
        done_cnt[d]++;
        cnt = 0;
      end else if (busy_v[d] === 1'b1) begin
        cnt++;
      end
      prev_done = done_v[d];
    end
  endtask

  initial decode_loop(0);
  initial decode_loop(1);
  initial idx_loop(0);
  initial idx_loop(1);
  initial busy_loop(0, LEN_CR);
  initial busy_loop(1, LEN_NO);

  task automatic push_line(input int d);
    for (int i = 0; i < 32; i++) begin
      if (d == 0) exp_a.push_back((i == 3) ? 8'h55 : 8'h20);
      else        exp_b.push_back(8'h40 + 8'(i));
    end
    if (d == 0) begin
      exp_a.push_back(8'h0D);
      exp_a.push_back(8'h0A);
    end
  endtask

  // start must already be high; counts edges from the accepting edge to tx low
  task automatic latency(input int d, input string name);
    int k;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    k = 1;
    while (tx_v[d] !== 1'b0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, k, 3);
  endtask

  task automatic wait_done(input int d, input string name);
    int t;
    t = 0;
    while (done_v[d] !== 1'b1 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    gen[0] = 0; gen[1] = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", {31'd0, tx_a}, 32'd1);
    check("reset busy", {31'd0, busy_a}, 32'd0);
    check("reset index", {27'd0, index_a}, 32'd0);
    check("reset done", {31'd0, done_a}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // line 1, with a start pulse 1000 clocks in that must be ignored
    push_line(0);
    start_a = 1'b1;
    latency(0, "first fetch latency");
    repeat (997) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_done(0, "line1 done timeout");

    // line 2 requested in the done cycle, then aborted mid DATA bit 4 of char 5
    push_line(0);
    start_a = 1'b1;
    latency(0, "back-to-back latency");
    repeat (564) @(posedge clk);
    #1;
    rst = 1'b1;
    gen[0]++;
    gen[1]++;
    exp_a.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort tx", {31'd0, tx_a}, 32'd1);
    check("abort busy", {31'd0, busy_a}, 32'd0);
    check("abort index", {27'd0, index_a}, 32'd0);
    check("abort done", {31'd0, done_a}, 32'd0);
    repeat (120) @(posedge clk);
    #1;

    // line 3 after the abort
    push_line(0);
    start_a = 1'b1;
    latency(0, "post-reset latency");
    wait_done(0, "line3 done timeout");
    repeat (10) @(posedge clk);
    #1;

    // no CR/LF instance
    push_line(1);
    start_b = 1'b1;
    latency(1, "no-crlf latency");
    wait_done(1, "no-crlf done timeout");
    repeat (300) @(posedge clk);
    #1;

    check("queue a drained", exp_a.size(), 32'd0);
    check("queue b drained", exp_b.size(), 32'd0);
    check("done count a", done_cnt[0], 32'd2);
    check("done count b", done_cnt[1], 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
